// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store engine with sub-word read-modify-write
// and sign/zero extension, fronting a word-addressed memory with combinational reads.
module load_store_unit #(
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [1:0]           reqSize,
    input  logic                 reqUnsigned,
    input  logic [ADDR_BITS-1:0] reqAddress,
    input  logic [31:0]          reqWriteData,
    output logic                 respValid,
    input  logic                 respReady,
    output logic [31:0]          respData,
    output logic                 respError,
    output logic [ADDR_BITS-1:0] memAddress,
    output logic [31:0]          memWriteData,
    output logic                 memEnableRead,
    output logic                 memEnableWrite,
    input  logic [31:0]          memReadData
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESPOND} state_t;
    state_t state_q, state_d;
    logic                 write_q, write_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]           size_q, size_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d, merge_q, merge_d, rdata_q, rdata_d;
    logic [4:0]  byte_sh, half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext, lane_mask, lane_ins, merged;
    logic        req_err, word_store, in_mem;
    assign byte_sh    = {addr_q[1:0], 3'b000};
    assign half_sh    = {addr_q[1], 4'b0000};
    assign lane_b     = 8'(memReadData >> byte_sh);
    assign lane_h     = 16'(memReadData >> half_sh);
    assign load_ext   = size_q == 2'b00 ? {{24{~uns_q & lane_b[7]}}, lane_b} :
                        size_q == 2'b01 ? {{16{~uns_q & lane_h[15]}}, lane_h} : memReadData;
    assign lane_mask  = size_q == 2'b00 ? 32'h0000_00FF << byte_sh : 32'h0000_FFFF << half_sh;
    assign lane_ins   = size_q == 2'b00 ? 32'(wdata_q[7:0]) << byte_sh : 32'(wdata_q[15:0]) << half_sh;
    assign merged     = (memReadData & ~lane_mask) | lane_ins;
    assign req_err    = reqSize == 2'b11 || (reqSize == 2'b01 && reqAddress[0]) ||
                        (reqSize == 2'b10 && reqAddress[1:0] != 2'b00);
    assign word_store = write_q && size_q == 2'b10;
    assign in_mem     = state_q == ACCESS || state_q == WRITE;
    // Every output is forced low while reset is asserted so an aborted access never strobes memory.
    assign reqReady       = reset && state_q == IDLE;
    assign respValid      = reset && state_q == RESPOND;
    assign respData       = respValid ? rdata_q : 32'h0;
    assign respError      = respValid && err_q;
    assign memEnableRead  = reset && state_q == ACCESS && !word_store;
    assign memEnableWrite = reset && ((state_q == ACCESS && word_store) || state_q == WRITE);
    assign memWriteData   = !memEnableWrite ? 32'h0 : state_q == WRITE ? merge_q : wdata_q;
    assign memAddress     = (reset && in_mem) ? {2'b00, addr_q[ADDR_BITS-1:2]} : '0;
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (reqValid) begin
                write_d = reqWrite;
                size_d  = reqSize;
                uns_d   = reqUnsigned;
                addr_d  = reqAddress;
                wdata_d = reqWriteData;
                err_d   = req_err;
                rdata_d = 32'h0;
                state_d = req_err ? RESPOND : ACCESS;
            end
            ACCESS: begin
                rdata_d = write_q ? 32'h0 : load_ext;
                merge_d = merged;
                state_d = (write_q && !word_store) ? WRITE : RESPOND;
            end
            WRITE:   state_d = RESPOND;
            RESPOND: state_d = respReady ? IDLE : RESPOND;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a
// word-array reference memory with arithmetic lane extraction and merging.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid = 1'b0, reqWrite = 1'b0, reqUnsigned = 1'b0, respReady = 1'b1;
    logic [1:0]  reqSize = 2'b00;
    logic [31:0] reqAddress = 32'h0, reqWriteData = 32'h0;
    logic        reqReady, respValid, respError, memEnableRead, memEnableWrite;
    logic [31:0] respData, memAddress, memWriteData, memReadData;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int vec = 0;
    int errs = 0;

    load_store_unit #(.ADDR_BITS(32)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
        .reqWrite(reqWrite), .reqSize(reqSize), .reqUnsigned(reqUnsigned),
        .reqAddress(reqAddress), .reqWriteData(reqWriteData), .respValid(respValid),
        .respReady(respReady), .respData(respData), .respError(respError),
        .memAddress(memAddress), .memWriteData(memWriteData), .memEnableRead(memEnableRead),
        .memEnableWrite(memEnableWrite), .memReadData(memReadData)
    );

    always #5 clk = ~clk;
    assign memReadData = mem[memAddress[7:0]];
    always @(posedge clk) if (memEnableWrite) mem[memAddress[7:0]] <= memWriteData;

    // Issues one request from a negedge, follows it to its response, holds respReady low for
    // `hold` cycles, and returns the observed respData. Ends on a negedge in IDLE.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] d, input int hold, output logic [31:0] got);
        logic [31:0] word, v, exp_data;
        logic exp_err;
        int exp_lat, exp_rd, exp_wr, n, rd, wr, k, sh;
        exp_err = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        exp_lat = exp_err ? 1 : (w && sz != 2'd2) ? 3 : 2;
        exp_rd  = (exp_err || (w && sz == 2'd2)) ? 0 : 1;
        exp_wr  = (!exp_err && w) ? 1 : 0;
        word = ref_mem[a[9:2]];
        k = int'(a[1:0]);
        sh = (sz == 2'd0) ? 8 * k : 16 * (k / 2);
        exp_data = 32'h0;
        if (!exp_err && !w) begin
            if (sz == 2'd0) begin
                v = (word >> sh) % 256;
                exp_data = (!u && v >= 128) ? v + 32'hFFFF_FF00 : v;
            end else if (sz == 2'd1) begin
                v = (word >> sh) % 65536;
                exp_data = (!u && v >= 32768) ? v + 32'hFFFF_0000 : v;
            end else exp_data = word;
        end
        if (!exp_err && w) begin
            if (sz == 2'd2) ref_mem[a[9:2]] = d;
            else if (sz == 2'd0) ref_mem[a[9:2]] = word - (((word >> sh) % 256) << sh) + ((d % 256) << sh);
            else ref_mem[a[9:2]] = word - (((word >> sh) % 65536) << sh) + ((d % 65536) << sh);
        end
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = u;
        reqAddress = a; reqWriteData = d; respReady = (hold == 0);
        vec++;
        if (reqReady !== 1'b1) begin errs++; $display("FAIL req_ready got %b exp 1", reqReady); end
        @(posedge clk); @(negedge clk);
        reqValid = 1'b0;
        n = 1; rd = 0; wr = 0;
        while (respValid !== 1'b1 && n < 8) begin
            if (memEnableRead === 1'b1) rd++;
            if (memEnableWrite === 1'b1) wr++;
            if (memEnableRead === 1'b1 || memEnableWrite === 1'b1) begin
                vec++;
                if (memAddress !== {2'b00, a[31:2]}) begin
                    errs++; $display("FAIL mem_addr got %h exp %h", memAddress, {2'b00, a[31:2]});
                end
            end
            if (memEnableWrite === 1'b1) begin
                vec++;
                if (memWriteData !== ref_mem[a[9:2]]) begin
                    errs++; $display("FAIL mem_wdata got %h exp %h", memWriteData, ref_mem[a[9:2]]);
                end
            end
            if (memEnableRead === 1'b1 && memEnableWrite === 1'b1) begin
                errs++; $display("FAIL strobe_overlap got rd=1 wr=1 exp exclusive");
            end
            @(posedge clk); @(negedge clk);
            n++;
        end
        vec++;
        if (n != exp_lat) begin errs++; $display("FAIL latency got %0d exp %0d (a=%h sz=%0d w=%b)", n, exp_lat, a, sz, w); end
        vec++;
        if (rd != exp_rd || wr != exp_wr) begin
            errs++; $display("FAIL strobes got rd=%0d wr=%0d exp rd=%0d wr=%0d", rd, wr, exp_rd, exp_wr);
        end
        vec++;
        if (respData !== exp_data || respError !== exp_err) begin
            errs++; $display("FAIL resp got %h/%b exp %h/%b (a=%h sz=%0d u=%b w=%b)", respData, respError, exp_data, exp_err, a, sz, u, w);
        end
        vec++;
        if ({memEnableRead, memEnableWrite} !== 2'b00 || memAddress !== 32'h0) begin
            errs++; $display("FAIL respond_mem got %b%b/%h exp 00/0", memEnableRead, memEnableWrite, memAddress);
        end
        got = respData;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            vec++;
            if (respValid !== 1'b1 || respData !== exp_data || respError !== exp_err || reqReady !== 1'b0) begin
                errs++; $display("FAIL stall got v=%b d=%h e=%b r=%b exp 1/%h/%b/0", respValid, respData, respError, reqReady, exp_data, exp_err);
            end
        end
        respReady = 1'b1;
        @(posedge clk); @(negedge clk);
        vec++;
        if (respValid !== 1'b0 || reqReady !== 1'b1) begin
            errs++; $display("FAIL back_to_idle got v=%b r=%b exp 0/1", respValid, reqReady);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; reqValid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++;
        if ({respValid, respError, memEnableRead, memEnableWrite, reqReady} !== 5'b0 ||
            respData !== 32'h0 || memAddress !== 32'h0 || memWriteData !== 32'h0) begin
            errs++; $display("FAIL reset_outputs got %b %h %h %h exp all zero",
                {respValid, respError, memEnableRead, memEnableWrite, reqReady}, respData, memAddress, memWriteData);
        end
        reqValid = 1'b0; reset = 1'b1;
        #1;
        vec++;
        if (reqReady !== 1'b1) begin errs++; $display("FAIL reset_release got %b exp 1", reqReady); end
    endtask

    task automatic test_directed();
        logic [31:0] g;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, g);
        vec++;
        if (mem[4] !== 32'hDEAD_BEEF) begin errs++; $display("FAIL word_store got %h exp deadbeef", mem[4]); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g);
        vec++;
        if (g !== 32'hDEAD_BEEF) begin errs++; $display("FAIL word_load got %h exp deadbeef", g); end
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, g);
        vec++;
        if (g !== 32'hFFFF_FFDE) begin errs++; $display("FAIL byte_signed got %h exp ffffffde", g); end
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, g);
        vec++;
        if (g !== 32'h0000_00DE) begin errs++; $display("FAIL byte_unsigned got %h exp 000000de", g); end
        do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0, g);
        vec++;
        if (g !== 32'hFFFF_BEEF) begin errs++; $display("FAIL half_signed got %h exp ffffbeef", g); end
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_5677, 0, g);
        vec++;
        if (mem[4] !== 32'hDEAD_77EF) begin errs++; $display("FAIL byte_store got %h exp dead77ef", mem[4]); end
        do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, g);
        do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFE_F00D, 0, g);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, g);
        vec++;
        if (g !== 32'h0 || mem[4] !== 32'hDEAD_77EF) begin
            errs++; $display("FAIL error_reqs got %h/%h exp 0/dead77ef", g, mem[4]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] g;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, g);
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_A5A5, 5, g);
    endtask

    task automatic test_reset_abort();
        logic [31:0] g;
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqUnsigned = 1'b0;
        reqAddress = 32'h21; reqWriteData = 32'h0000_0055;
        @(posedge clk); @(negedge clk);
        reqValid = 1'b0;
        @(posedge clk); @(negedge clk);
        vec++;
        if (memEnableWrite !== 1'b1) begin errs++; $display("FAIL abort_in_write got %b exp 1", memEnableWrite); end
        reset = 1'b0;
        #1;
        vec++;
        if (memEnableWrite !== 1'b0) begin errs++; $display("FAIL abort_strobe got %b exp 0", memEnableWrite); end
        @(posedge clk); @(negedge clk);
        vec++;
        if (memEnableWrite !== 1'b0 || respValid !== 1'b0 || mem[8] !== ref_mem[8]) begin
            errs++; $display("FAIL abort_after got wr=%b v=%b mem=%h exp 0/0/%h", memEnableWrite, respValid, mem[8], ref_mem[8]);
        end
        reset = 1'b1;
        #1;
        vec++;
        if (reqReady !== 1'b1 || respValid !== 1'b0) begin
            errs++; $display("FAIL abort_idle got r=%b v=%b exp 1/0", reqReady, respValid);
        end
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, g);
    endtask

    task automatic test_back_to_back();
        logic [31:0] g;
        for (int i = 0; i < 300; i++)
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 63)), $urandom, (i % 7 == 0) ? int'($urandom_range(1, 3)) : 0, g);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_directed();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
